// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request in flight to
// instruction memory and presents fetched words through a buffer plus skid slot.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      hazard_signal,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
);

  // Hazard encodings shared with the pipeline registers (inst_defs.v).
  localparam logic [3:0] HZ_STALL_EARLY = 4'd1;
  localparam logic [3:0] HZ_FLUSH_EARLY = 4'd2;
  localparam logic [3:0] HZ_FLUSH_ALL   = 4'd3;
  localparam logic [3:0] HZ_STALL_MMU   = 4'd4;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] inflight_pc, inflight_pc_nxt;
  logic            outstanding, outstanding_nxt;
  logic            drop, drop_nxt;

  logic            obuf_valid, obuf_valid_nxt;
  logic [XLEN-1:0] obuf_pc, obuf_pc_nxt;
  logic [XLEN-1:0] obuf_inst, obuf_inst_nxt;
  logic            skid_valid, skid_valid_nxt;
  logic [XLEN-1:0] skid_pc, skid_pc_nxt;
  logic [XLEN-1:0] skid_inst, skid_inst_nxt;

  logic stall;
  logic flush;
  logic accept;
  logic resp_take;
  logic handshake;

  assign stall  = (hazard_signal == HZ_STALL_EARLY) | (hazard_signal == HZ_STALL_MMU);
  assign flush  = redirect_valid | (hazard_signal == HZ_FLUSH_EARLY) |
                  (hazard_signal == HZ_FLUSH_ALL);
  assign accept = obuf_valid & ~redirect_valid & ~stall;

  // Responses owed to a killed request, or arriving during a flush, are discarded.
  assign resp_take = imem_resp_valid & ~drop & ~flush;

  always_comb begin
    obuf_valid_nxt = obuf_valid;
    obuf_pc_nxt    = obuf_pc;
    obuf_inst_nxt  = obuf_inst;
    skid_valid_nxt = skid_valid;
    skid_pc_nxt    = skid_pc;
    skid_inst_nxt  = skid_inst;

    if (flush) begin
      obuf_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (resp_take) begin
      if (!obuf_valid) begin
        obuf_valid_nxt = 1'b1;
        obuf_pc_nxt    = inflight_pc;
        obuf_inst_nxt  = imem_resp_data;
      end else if (accept) begin
        if (skid_valid) begin
          obuf_pc_nxt   = skid_pc;
          obuf_inst_nxt = skid_inst;
          skid_pc_nxt   = inflight_pc;
          skid_inst_nxt = imem_resp_data;
        end else begin
          obuf_pc_nxt   = inflight_pc;
          obuf_inst_nxt = imem_resp_data;
        end
      end else begin
        skid_valid_nxt = 1'b1;
        skid_pc_nxt    = inflight_pc;
        skid_inst_nxt  = imem_resp_data;
      end
    end else if (accept) begin
      if (skid_valid) begin
        obuf_pc_nxt    = skid_pc;
        obuf_inst_nxt  = skid_inst;
        skid_valid_nxt = 1'b0;
      end else begin
        obuf_valid_nxt = 1'b0;
      end
    end
  end

  // Only issue when the skid will have room for the answer, so nothing is ever lost.
  assign imem_req_valid = ~rst & ~redirect_valid & (hazard_signal != HZ_STALL_MMU) &
                          (~outstanding | imem_resp_valid) & ~skid_valid_nxt;
  assign imem_req_addr  = fetch_pc;
  assign handshake      = imem_req_valid & imem_req_ready;

  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    inflight_pc_nxt = inflight_pc;
    outstanding_nxt = outstanding;
    drop_nxt        = drop;

    if (redirect_valid) begin
      fetch_pc_nxt = redirect_pc & ~XLEN'(3);
    end else if (handshake) begin
      fetch_pc_nxt = fetch_pc + XLEN'(4);
    end

    if (handshake) begin
      inflight_pc_nxt = fetch_pc;
    end

    if (imem_resp_valid) begin
      outstanding_nxt = 1'b0;
      drop_nxt        = 1'b0;
    end
    if (handshake) begin
      outstanding_nxt = 1'b1;
    end
    if (flush && outstanding && !imem_resp_valid) begin
      drop_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      obuf_valid  <= 1'b0;
      obuf_pc     <= '0;
      obuf_inst   <= NOP;
      skid_valid  <= 1'b0;
      skid_pc     <= '0;
      skid_inst   <= NOP;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      inflight_pc <= inflight_pc_nxt;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      obuf_valid  <= obuf_valid_nxt;
      obuf_pc     <= obuf_pc_nxt;
      obuf_inst   <= obuf_inst_nxt;
      skid_valid  <= skid_valid_nxt;
      skid_pc     <= skid_pc_nxt;
      skid_inst   <= skid_inst_nxt;
    end
  end

  assign if_valid = obuf_valid;
  assign if_pc    = obuf_pc;
  assign if_inst  = obuf_inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory model plus
// a scoreboard of expected fetch PCs, popped whenever the stage hands an instruction on.
module tb_fetch_unit;

  localparam logic [3:0]  HZ_NONE        = 4'd0;
  localparam logic [3:0]  HZ_STALL_EARLY = 4'd1;
  localparam logic [3:0]  HZ_FLUSH_EARLY = 4'd2;
  localparam logic [3:0]  HZ_FLUSH_ALL   = 4'd3;
  localparam logic [3:0]  HZ_STALL_MMU   = 4'd4;
  localparam logic [31:0] RESET_PC       = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  hazard_signal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int checks = 0;
  int fails  = 0;

  logic [31:0] sb[$];
  logic [31:0] exp_req;
  logic [31:0] popped;

  int          mem_lat = 1;
  bit          rand_ready = 1'b0;
  bit          pend;
  int          cnt;
  logic [31:0] paddr;
  bit          hs_s;
  logic [31:0] hs_a;
  bit          rst_s;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_signal   (hazard_signal),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [3:0] hz, input logic rv, input logic [31:0] rpc,
                               input int n);
    for (int i = 0; i < n; i++) begin
      hazard_signal  = hz;
      redirect_valid = rv;
      redirect_pc    = rpc;
      step();
    end
    hazard_signal  = HZ_NONE;
    redirect_valid = 1'b0;
  endtask

  task automatic waitForPc(input logic [31:0] pc, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (if_valid && if_pc == pc) ok = 1'b1;
      else step();
    end
    checkOutput(tag, 32'(ok), 32'd1);
  endtask

  task automatic waitForReq(input logic [31:0] a, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      #1;
      if (imem_req_valid && imem_req_ready && imem_req_addr == a) ok = 1'b1;
      step();
    end
    checkOutput(tag, 32'(ok), 32'd1);
  endtask

  // Memory model: one request at a time, answered mem_lat cycles after the handshake.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_req_ready  = 1'b1;
    pend            = 1'b0;
    forever begin
      @(negedge clk);
      hs_s  = imem_req_valid && imem_req_ready;
      hs_a  = imem_req_addr;
      rst_s = rst;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst_s) begin
        pend = 1'b0;
      end else begin
        if (hs_s) begin
          pend  = 1'b1;
          paddr = hs_a;
          cnt   = mem_lat;
        end
        if (pend) begin
          cnt--;
          if (cnt <= 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(paddr);
            pend            = 1'b0;
          end
        end
      end
      imem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Scoreboard: handshakes push the expected PC; flushes empty it; accepted outputs pop it.
  initial begin
    exp_req = RESET_PC;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        exp_req = RESET_PC;
      end else begin
        if (redirect_valid || hazard_signal == HZ_FLUSH_EARLY || hazard_signal == HZ_FLUSH_ALL) begin
          sb.delete();
          if (redirect_valid) begin
            exp_req = redirect_pc & ~32'd3;
            checkOutput("req_during_redirect", 32'(imem_req_valid), 32'd0);
          end
        end else if (if_valid && hazard_signal != HZ_STALL_EARLY && hazard_signal != HZ_STALL_MMU) begin
          if (sb.size() == 0) begin
            checkOutput("sb_unexpected_output", if_pc, 32'hFFFF_FFFF);
          end else begin
            popped = sb.pop_front();
            checkOutput("if_pc", if_pc, popped);
            checkOutput("if_inst", if_inst, inst_of(popped));
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          checkOutput("req_addr", imem_req_addr, exp_req);
          sb.push_back(exp_req);
          exp_req = exp_req + 32'd4;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    int first_hs;
    int first_v;
    int k;
    int r;

    rst            = 1'b1;
    hazard_signal  = HZ_NONE;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_inst", if_inst, 32'h0000_0013);
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);

    // Reset release, 1-cycle memory: latency 2 and one instruction per cycle.
    rst      = 1'b0;
    first_hs = -1;
    first_v  = -1;
    k        = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (first_hs < 0 && imem_req_valid && imem_req_ready) first_hs = i;
      if (if_valid) begin
        if (first_v < 0) first_v = i;
        checkOutput("steady_pc", if_pc, 32'(4 * k));
        k++;
      end
      step();
    end
    checkOutput("first_hs_cycle", 32'(first_hs), 32'd0);
    checkOutput("first_valid_latency", 32'(first_v - first_hs), 32'd2);
    checkOutput("steady_count", 32'(k), 32'd8);

    // STALL_EARLY for 3 cycles with 0x8 presented.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    waitForPc(32'h8, 20, "wait_pc_8");
    for (int i = 0; i < 3; i++) begin
      hazard_signal = HZ_STALL_EARLY;
      #1;
      checkOutput("stall_early_if_pc", if_pc, 32'h8);
      checkOutput("stall_early_req_valid", 32'(imem_req_valid), 32'd0);
      step();
    end
    hazard_signal = HZ_NONE;
    mem_lat       = 3;
    step();
    checkOutput("post_stall_valid", 32'(if_valid), 32'd1);
    checkOutput("post_stall_pc", if_pc, 32'hC);

    // Redirect while the 0x14 request is outstanding: its response must be dropped.
    waitForReq(32'h14, 30, "wait_req_14");
    applyStimulus(HZ_NONE, 1'b1, 32'h100, 1);
    waitForReq(32'h100, 20, "wait_req_100");
    waitForPc(32'h100, 20, "wait_pc_100");

    // Redirect in the same cycle as the response.
    mem_lat = 1;
    waitForReq(32'h108, 40, "wait_req_108");
    #1;
    checkOutput("same_cycle_resp_present", 32'(imem_resp_valid), 32'd1);
    applyStimulus(HZ_NONE, 1'b1, 32'h200, 1);
    waitForPc(32'h200, 20, "wait_pc_200");

    // STALL_MMU for 4 cycles with a 3-cycle memory.
    mem_lat = 3;
    waitForReq(32'h210, 60, "wait_req_210");
    for (int i = 0; i < 4; i++) begin
      hazard_signal = HZ_STALL_MMU;
      #1;
      checkOutput("stall_mmu_req_valid", 32'(imem_req_valid), 32'd0);
      step();
    end
    hazard_signal = HZ_NONE;
    waitForPc(32'h214, 40, "wait_pc_214");

    // PC wrap at the top of the address space.
    mem_lat = 1;
    applyStimulus(HZ_NONE, 1'b1, 32'hFFFF_FFF8, 1);
    waitForReq(32'hFFFF_FFFC, 20, "wait_req_fffffffc");
    #1;
    checkOutput("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("wrap_req_addr", imem_req_addr, 32'h0);
    waitForPc(32'h0, 20, "wait_pc_wrap");

    // Reset asserted during a stall.
    hazard_signal = HZ_STALL_EARLY;
    step();
    step();
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    checkOutput("rst_mid_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_mid_if_pc", if_pc, 32'd0);
    checkOutput("rst_mid_if_inst", if_inst, 32'h0000_0013);
    rst           = 1'b0;
    hazard_signal = HZ_NONE;
    waitForReq(RESET_PC, 5, "wait_req_reset_pc");

    // Random hazards, redirects, latencies and back-pressure; the scoreboard checks.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      mem_lat        = $urandom_range(1, 3);
      r              = $urandom_range(0, 99);
      redirect_valid = 1'b0;
      if (r < 70)      hazard_signal = HZ_NONE;
      else if (r < 82) hazard_signal = HZ_STALL_EARLY;
      else if (r < 90) hazard_signal = HZ_STALL_MMU;
      else if (r < 94) hazard_signal = HZ_FLUSH_EARLY;
      else if (r < 96) hazard_signal = HZ_FLUSH_ALL;
      else begin
        hazard_signal  = HZ_NONE;
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'h0000_0FFF;
      end
      step();
    end
    hazard_signal  = HZ_NONE;
    redirect_valid = 1'b0;
    rand_ready     = 1'b0;
    mem_lat        = 1;
    repeat (10) step();
    checkOutput("final_progress_valid", 32'(if_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
